// File: rtl/system_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// system_pll_reset_ctrl
//
// Reset and lock sequencer for the system PLL, clocked by the free-running
// reference clock (never by the PLL output). Each attempt pulses the PLL
// reset, waits for a synchronized lock, requires the lock to hold for a
// number of consecutive cycles, and only then releases the downstream
// system reset. Lock timeouts trigger a bounded number of retries before a
// sticky fail state; lock loss while running re-sequences the PLL.
//
// Ports
//   refclk       in   free-running reference clock (only clock here)
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock, asynchronous to refclk
//   retry_req    in   single-cycle pulse, leaves FAIL (ignored elsewhere)
//   pll_rst      out  PLL reset, active-high
//   sys_rst      out  downstream reset, active-high, refclk domain
//   ready        out  PLL locked and stable, system out of reset
//   fail         out  retries exhausted
//   retry_cnt    out  lock timeouts in the current sequence
//   loss_cnt     out  lock-loss events while running, saturating at 255
//   dbg_state_o  out  current FSM state (state_e encoding)
//
// Handshake: there is no valid/ready pair. retry_req is a level sampled on
// every refclk edge and acted on only while in FAIL; ready is a status
// level that is high exactly while the FSM is in RUN.
// ---------------------------------------------------------------------------
module system_pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] dbg_state_o
);

  // One shared counter sized for the largest of the three durations.
  localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_AB > LOCK_STABLE_CYCLES) ?
                                    MAX_AB : LOCK_STABLE_CYCLES;
  localparam int          CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  // Terminal counts: the counter is 0 on the edge that enters a state, so
  // the Nth edge spent in a state sees the value N-1.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       MAX_R       = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q, lock_s_q;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous PLL lock. Only lock_s_q is
  // allowed to reach the FSM.
  // -------------------------------------------------------------------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // State register, counters and registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      loss_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_LOCK: begin
        // Lock is checked first, so a lock arriving on the timeout edge wins.
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == MAX_R) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = S_RESET_PLL;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STABLE: begin
        // A glitch drops back to WAIT_LOCK with a fresh timeout but keeps
        // the retry count: it is not a timeout.
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        if (!lock_s_q) begin
          if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
          retry_d = 4'd0;
          state_d = S_RESET_PLL;
        end
      end

      S_FAIL: begin
        if (retry_req) begin
          retry_d = 4'd0;
          state_d = S_RESET_PLL;
        end
      end

      default: begin
        state_d = S_RESET_PLL;
      end
    endcase

    // Every state change restarts the shared counter.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from the next state so they switch on the same edge as
  // the transition that causes them.
  // -------------------------------------------------------------------------
  always_comb begin
    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_cnt   = retry_q;
  assign loss_cnt    = loss_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_system_pll_reset_ctrl.sv
module tb_system_pll_reset_ctrl;

  localparam int RP = 4;
  localparam int LT = 20;
  localparam int LS = 8;
  localparam int MR = 2;

  // Reference-model phases (independent of the RTL encoding)
  localparam int PH_RST  = 10;
  localparam int PH_WAIT = 11;
  localparam int PH_STAB = 12;
  localparam int PH_RUN  = 13;
  localparam int PH_FAIL = 14;

  localparam logic [15:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};

  // ---------------- clock / reset block ----------------
  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       retry_req = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] dbg_state;

  always #5 refclk = ~refclk;

  system_pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(LT),
    .LOCK_STABLE_CYCLES (LS),
    .MAX_RETRIES        (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .retry_req  (retry_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .dbg_state_o(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // ---------------- reference model ----------------
  // Phase plus the edge number at which it was entered; durations are
  // elapsed edge counts. The synchronizer is a 2-deep lock history.
  int m_phase = PH_RST;
  int m_entry = 0;
  int m_retry = 0;
  int m_loss  = 0;
  bit m_h1 = 1'b0;
  bit m_h2 = 1'b0;

  task automatic enter(input int ph);
    m_phase = ph;
    m_entry = cyc;
  endtask

  task automatic model_step(input bit r, input bit lk, input bit rq);
    bit ls;
    int el;
    ls   = m_h2;
    m_h2 = m_h1;
    m_h1 = lk;
    if (r) begin
      enter(PH_RST);
      m_retry = 0;
      m_loss  = 0;
      m_h1    = 1'b0;
      m_h2    = 1'b0;
      return;
    end
    el = cyc - m_entry;
    case (m_phase)
      PH_RST:  if (el == RP) enter(PH_WAIT);
      PH_WAIT: begin
        if (ls) enter(PH_STAB);
        else if (el == LT) begin
          if (m_retry == MR) enter(PH_FAIL);
          else begin
            m_retry++;
            enter(PH_RST);
          end
        end
      end
      PH_STAB: begin
        if (!ls) enter(PH_WAIT);
        else if (el == LS) enter(PH_RUN);
      end
      PH_RUN: begin
        if (!ls) begin
          if (m_loss < 255) m_loss++;
          m_retry = 0;
          enter(PH_RST);
        end
      end
      PH_FAIL: begin
        if (rq) begin
          m_retry = 0;
          enter(PH_RST);
        end
      end
      default: enter(PH_RST);
    endcase
  endtask

  function automatic logic [15:0] exp_vec();
    logic [3:0] r4;
    logic [7:0] l8;
    r4 = m_retry[3:0];
    l8 = m_loss[7:0];
    return {(m_phase == PH_RST) || (m_phase == PH_FAIL), m_phase != PH_RUN,
            m_phase == PH_RUN, m_phase == PH_FAIL, r4, l8};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one edge; the model sees the same inputs the DUT samples.
  task automatic tick();
    @(posedge refclk);
    cyc++;
    model_step(rst, pll_locked, retry_req);
    #1;
  endtask

  task automatic reset_release(input bit lk);
    rst = 1'b1;
    pll_locked = lk;
    retry_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_clean_lock();
    int first_low, ready_at;
    first_low = -1;
    ready_at  = -1;
    reset_release(1'b0);
    for (int i = 1; i <= 40; i++) begin
      if (i == 11) pll_locked = 1'b1;
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL clean_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (first_low < 0 && !pll_rst) first_low = i;
      if (ready_at < 0 && ready) ready_at = i;
    end
    n_tests++;
    if (first_low !== RP) begin
      n_fail++;
      $display("FAIL clean_pulse_width got=%0d exp=%0d", first_low, RP);
    end
    n_tests++;
    if (ready_at !== 10 + 2 + 1 + LS) begin
      n_fail++;
      $display("FAIL clean_ready_edge got=%0d exp=%0d", ready_at, 10 + 2 + 1 + LS);
    end
    n_tests++;
    if ({sys_rst, retry_cnt} !== 5'd0) begin
      n_fail++;
      $display("FAIL clean_sysrst_retry got=%b/%0d exp=0/0", sys_rst, retry_cnt);
    end
  endtask

  task automatic test_glitchy_lock();
    int ready_at;
    ready_at = -1;
    reset_release(1'b0);
    for (int i = 1; i <= 45; i++) begin
      if (i == 11) pll_locked = 1'b1;
      if (i == 16) pll_locked = 1'b0;
      if (i == 19) pll_locked = 1'b1;
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (ready_at < 0 && ready) ready_at = i;
    end
    n_tests++;
    if (ready_at !== 18 + 2 + 1 + LS) begin
      n_fail++;
      $display("FAIL glitch_ready_edge got=%0d exp=%0d", ready_at, 18 + 2 + 1 + LS);
    end
    n_tests++;
    if (retry_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL glitch_retry got=%0d exp=0", retry_cnt);
    end
  endtask

  task automatic test_timeout_retry();
    int rise_at, fall_at, ready_at;
    bit prev;
    rise_at = -1;
    fall_at = -1;
    ready_at = -1;
    prev = 1'b0;
    reset_release(1'b0);
    for (int i = 1; i <= 50; i++) begin
      if (i == 31) pll_locked = 1'b1;
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL timeout_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (i > RP && rise_at < 0 && pll_rst && !prev) rise_at = i;
      if (rise_at > 0 && fall_at < 0 && !pll_rst) fall_at = i;
      if (ready_at < 0 && ready) ready_at = i;
      prev = pll_rst;
    end
    n_tests++;
    if (rise_at !== RP + LT || fall_at - rise_at !== RP) begin
      n_fail++;
      $display("FAIL timeout_second_pulse got=%0d..%0d exp=%0d..%0d",
               rise_at, fall_at, RP + LT, 2 * RP + LT);
    end
    n_tests++;
    if (ready_at !== 30 + 2 + 1 + LS || retry_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL timeout_ready_retry got=%0d/%0d exp=%0d/1",
               ready_at, retry_cnt, 30 + 2 + 1 + LS);
    end
  endtask

  // Lock reaches lock_s exactly on the timeout edge: lock must win.
  task automatic test_lock_race();
    int ready_at, rerise;
    ready_at = -1;
    rerise = 0;
    reset_release(1'b0);
    for (int i = 1; i <= 40; i++) begin
      if (i == RP + LT - 2) pll_locked = 1'b1;
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL race_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (i > RP && pll_rst) rerise = 1;
      if (ready_at < 0 && ready) ready_at = i;
    end
    n_tests++;
    if (rerise !== 0 || retry_cnt !== 4'd0 || ready_at !== RP + LT + LS) begin
      n_fail++;
      $display("FAIL race_lock_wins got=rerise%0d/retry%0d/ready@%0d exp=0/0/%0d",
               rerise, retry_cnt, ready_at, RP + LT + LS);
    end
  endtask

  task automatic test_exhaustion();
    int fail_at, low_at;
    fail_at = -1;
    low_at = -1;
    reset_release(1'b0);
    for (int i = 1; i <= 100 && fail_at < 0; i++) begin
      retry_req = (i == 10);  // ignored outside FAIL
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL exhaust_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (fail) fail_at = i;
    end
    retry_req = 1'b0;
    n_tests++;
    if (fail_at !== (RP + LT) * (MR + 1) || retry_cnt !== 4'(MR) || pll_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL exhaust_enter got=@%0d/retry%0d/pllrst%b exp=@%0d/%0d/1",
               fail_at, retry_cnt, pll_rst, (RP + LT) * (MR + 1), MR);
    end
    repeat (5) tick();
    n_tests++;
    if (fail !== 1'b1 || pll_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL exhaust_sticky got=fail%b/pllrst%b exp=1/1", fail, pll_rst);
    end
    retry_req = 1'b1;
    tick();
    retry_req = 1'b0;
    n_tests++;
    if ({fail, retry_cnt, pll_rst} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL exhaust_retry_req got=fail%b/retry%0d/pllrst%b exp=0/0/1",
               fail, retry_cnt, pll_rst);
    end
    for (int i = 1; i <= 10 && low_at < 0; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL exhaust_repulse cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (!pll_rst) low_at = i;
    end
    n_tests++;
    if (low_at !== RP) begin
      n_fail++;
      $display("FAIL exhaust_new_pulse got=%0d exp=%0d", low_at, RP);
    end
  endtask

  task automatic test_lock_loss();
    int drop_edges, waited;
    reset_release(1'b1);
    for (int n = 1; n <= 300; n++) begin
      waited = 0;
      while (!ready && waited < 40) begin
        tick();
        waited++;
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL loss_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        end
      end
      if (!ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL loss_wait_ready got=0 exp=1 (timeout at loss %0d)", n);
        return;
      end
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      drop_edges = 1;
      while (ready && drop_edges < 6) begin
        tick();
        drop_edges++;
      end
      if (n == 1) begin
        n_tests++;
        if (drop_edges > 3 || sys_rst !== 1'b1 || loss_cnt !== 8'd1 || retry_cnt !== 4'd0) begin
          n_fail++;
          $display("FAIL loss_first got=edges%0d/sysrst%b/loss%0d exp=<=3/1/1",
                   drop_edges, sys_rst, loss_cnt);
        end
      end
    end
    n_tests++;
    if (loss_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL loss_saturate got=%0d exp=255", loss_cnt);
    end
    repeat (20) tick();  // settle back into RUN
  endtask

  task automatic test_reset_mid();
    int waited;
    // reset while running (loss_cnt is nonzero from the previous test)
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre_run got=%b exp=1", ready);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL midrst_run got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    rst = 1'b0;
    waited = 0;
    while (m_phase != PH_STAB && waited < 30) begin
      tick();
      waited++;
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL midrst_stable got=%h exp=%h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_random();
    int seg_left;
    seg_left = 0;
    reset_release(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (seg_left == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        seg_left = $urandom_range(1, 30);
      end
      seg_left--;
      retry_req = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    rst = 1'b0;
    retry_req = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_lock();
    test_glitchy_lock();
    test_timeout_retry();
    test_lock_race();
    test_exhaustion();
    test_lock_loss();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
